// File: rtl/fractal_sync_local_rf_sched.sv
// Round-robin scheduler sharing one 2-port fractal sync local RF between N_REQ requesters.
// Grants up to two requests per cycle, classifies RF results and wakes stored waiters.
module fractal_sync_local_rf_sched #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2,
  parameter int N_REGS   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*ID_WIDTH-1:0] req_id_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [2*N_REQ-1:0]        rsp_status_o,
  output logic [N_REQ-1:0]          wake_o,
  output logic [2*ID_WIDTH-1:0]     rf_id_o,
  output logic [1:0]                rf_check_o,
  input  logic [1:0]                rf_present_i,
  input  logic [1:0]                rf_id_err_i,
  input  logic                      rf_bypass_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_STORED = 2'b00,
    ST_SYNC   = 2'b01,
    ST_ERROR  = 2'b10
  } status_e;

  if (N_REGS != 2**ID_WIDTH) begin : g_regs_check
    $error("N_REGS must equal 2**ID_WIDTH");
  end
  if (N_REQ < 2) begin : g_req_check
    $error("N_REQ must be at least 2");
  end

  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]                 waiting_q, waiting_d;
  logic [N_REGS-1:0]                wait_vld_q, wait_vld_d;
  logic [N_REGS-1:0][PTR_W-1:0]     waiter_q, waiter_d;
  logic [N_REQ-1:0]                 rsp_valid_d, wake_d;
  logic [2*N_REQ-1:0]               rsp_status_d;

  logic [N_REQ-1:0]                 eligible;
  logic                             a_vld, b_vld, same_vld, diff_vld;
  logic [PTR_W-1:0]                 a_idx, b_idx, same_idx, diff_idx;
  logic [ID_WIDTH-1:0]              a_id;
  logic [1:0]                       port_vld;
  logic [1:0][PTR_W-1:0]            port_req;
  logic [1:0][ID_WIDTH-1:0]         port_id;

  // Arbitration: winner A from the rr pointer, then a same-id partner unless the
  // entry is protected by a waiter, else the next partner with a different id.
  always_comb begin
    int idx;
    idx      = 0;
    eligible = req_valid_i & ~waiting_q & {N_REQ{~rst_i}};
    a_vld    = 1'b0;
    a_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_REQ;
      if (!a_vld && eligible[idx]) begin
        a_vld = 1'b1;
        a_idx = PTR_W'(idx);
      end
    end
    a_id = req_id_i[int'(a_idx)*ID_WIDTH +: ID_WIDTH];

    same_vld = 1'b0;
    same_idx = '0;
    diff_vld = 1'b0;
    diff_idx = '0;
    for (int i = 1; i < N_REQ; i++) begin
      idx = (int'(a_idx) + i) % N_REQ;
      if (eligible[idx]) begin
        if (req_id_i[idx*ID_WIDTH +: ID_WIDTH] == a_id) begin
          if (!same_vld) begin
            same_vld = 1'b1;
            same_idx = PTR_W'(idx);
          end
        end else if (!diff_vld) begin
          diff_vld = 1'b1;
          diff_idx = PTR_W'(idx);
        end
      end
    end

    b_vld = 1'b0;
    b_idx = '0;
    if (a_vld && same_vld && !wait_vld_q[a_id]) begin
      b_vld = 1'b1;
      b_idx = same_idx;
    end else if (a_vld && diff_vld) begin
      b_vld = 1'b1;
      b_idx = diff_idx;
    end
  end

  // RF port drive; an idle port 1 gets a different id so the RF never sees bypass.
  always_comb begin
    req_ready_o = '0;
    rf_id_o     = {ID_WIDTH'(1), ID_WIDTH'(0)};
    rf_check_o  = 2'b00;
    port_vld    = {b_vld, a_vld};
    port_req[0] = a_idx;
    port_req[1] = b_idx;
    port_id[0]  = a_id;
    port_id[1]  = req_id_i[int'(b_idx)*ID_WIDTH +: ID_WIDTH];
    if (a_vld) begin
      req_ready_o[a_idx]                 = 1'b1;
      rf_id_o[ID_WIDTH-1:0]              = a_id;
      rf_id_o[2*ID_WIDTH-1:ID_WIDTH]     = a_id ^ ID_WIDTH'(1);
      rf_check_o[0]                      = 1'b1;
    end
    if (b_vld) begin
      req_ready_o[b_idx]                 = 1'b1;
      rf_id_o[2*ID_WIDTH-1:ID_WIDTH]     = port_id[1];
      rf_check_o[1]                      = 1'b1;
    end
  end

  // Classification and waiter table update; granted ports never share a table
  // entry unless the RF bypasses, which leaves the table untouched.
  always_comb begin
    status_e st;
    st           = ST_STORED;
    wait_vld_d   = wait_vld_q;
    waiter_d     = waiter_q;
    waiting_d    = waiting_q;
    rsp_valid_d  = '0;
    rsp_status_d = '0;
    wake_d       = '0;
    rr_ptr_d     = rr_ptr_q;
    for (int p = 0; p < 2; p++) begin
      if (port_vld[p]) begin
        rsp_valid_d[port_req[p]] = 1'b1;
        if (rf_id_err_i[p]) begin
          st = ST_ERROR;
        end else if (rf_bypass_i) begin
          st = ST_SYNC;
        end else if (rf_present_i[p]) begin
          st                                = ST_SYNC;
          wake_d[waiter_q[port_id[p]]]      = 1'b1;
          waiting_d[waiter_q[port_id[p]]]   = 1'b0;
          wait_vld_d[port_id[p]]            = 1'b0;
        end else begin
          st                                = ST_STORED;
          waiter_d[port_id[p]]              = port_req[p];
          wait_vld_d[port_id[p]]            = 1'b1;
          waiting_d[port_req[p]]            = 1'b1;
        end
        rsp_status_d[int'(port_req[p])*2 +: 2] = st;
      end
    end
    if (a_vld) begin
      rr_ptr_d = PTR_W'((int'(a_idx) + 1) % N_REQ);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      waiting_q    <= '0;
      wait_vld_q   <= '0;
      waiter_q     <= '0;
      rsp_valid_o  <= '0;
      rsp_status_o <= '0;
      wake_o       <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      waiting_q    <= waiting_d;
      wait_vld_q   <= wait_vld_d;
      waiter_q     <= waiter_d;
      rsp_valid_o  <= rsp_valid_d;
      rsp_status_o <= rsp_status_d;
      wake_o       <= wake_d;
    end
  end

endmodule

// File: tb/tb_fractal_sync_local_rf_sched.sv
// Self-checking bench for fractal_sync_local_rf_sched with a behavioural RF and
// a barrier-ownership reference model.
module tb_fractal_sync_local_rf_sched;

  localparam int N_REQ  = 4;
  localparam int IDW    = 2;
  localparam int N_REGS = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [N_REQ-1:0]      req_valid_i = '0;
  logic [N_REQ*IDW-1:0]  req_id_i = '0;
  logic [N_REQ-1:0]      req_ready_o;
  logic [N_REQ-1:0]      rsp_valid_o;
  logic [2*N_REQ-1:0]    rsp_status_o;
  logic [N_REQ-1:0]      wake_o;
  logic [2*IDW-1:0]      rf_id_o;
  logic [1:0]            rf_check_o;
  logic [1:0]            rf_present_i;
  logic [1:0]            rf_id_err_i;
  logic                  rf_bypass_i;

  fractal_sync_local_rf_sched #(
    .N_REQ(N_REQ), .ID_WIDTH(IDW), .N_REGS(N_REGS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_id_i(req_id_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_status_o(rsp_status_o), .wake_o(wake_o),
    .rf_id_o(rf_id_o), .rf_check_o(rf_check_o), .rf_present_i(rf_present_i),
    .rf_id_err_i(rf_id_err_i), .rf_bypass_i(rf_bypass_i)
  );

  initial forever #5 clk_i = ~clk_i;

  // Behavioural local RF driven by the DUT's ports.
  logic       rf_mem [N_REGS];
  logic [1:0] inj_err = 2'b00;
  assign rf_present_i[0] = rf_mem[rf_id_o[IDW-1:0]];
  assign rf_present_i[1] = rf_mem[rf_id_o[2*IDW-1:IDW]];
  assign rf_bypass_i     = (rf_id_o[IDW-1:0] == rf_id_o[2*IDW-1:IDW]);
  assign rf_id_err_i     = inj_err;

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_REGS; i++) rf_mem[i] <= 1'b0;
    end else if (rf_bypass_i) begin
      rf_mem[rf_id_o[IDW-1:0]] <= 1'b0;
    end else begin
      if (rf_check_o[0] && !rf_id_err_i[0]) rf_mem[rf_id_o[IDW-1:0]] <= ~rf_present_i[0];
      if (rf_check_o[1] && !rf_id_err_i[1]) rf_mem[rf_id_o[2*IDW-1:IDW]] <= ~rf_present_i[1];
    end
  end

  int checks = 0;
  int errors = 0;

  // Stimulus state
  logic                 tb_rst = 1'b0;
  logic [N_REQ-1:0]     tb_valid = '0;
  logic [N_REQ*IDW-1:0] tb_id = '0;

  // Reference model: which requester owns (waits on) each barrier id, -1 if none.
  int owner [N_REGS] = '{default: -1};
  int m_rr = 0;
  int m_a, m_b;
  logic [N_REQ-1:0]   exp_ready, exp_rsp_valid, exp_wake;
  logic [2*N_REQ-1:0] exp_status;
  logic [2*IDW-1:0]   exp_rf_id;
  logic [1:0]         exp_rf_check;

  function automatic int id_of(input int k);
    return int'(tb_id[k*IDW +: IDW]);
  endfunction

  function automatic bit is_waiting(input int k);
    for (int i = 0; i < N_REGS; i++) if (owner[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_grant();
    int elig[$];
    int k;
    m_a = -1;
    m_b = -1;
    exp_ready    = '0;
    exp_rf_check = 2'b00;
    exp_rf_id    = {IDW'(1), IDW'(0)};
    if (!tb_rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        k = (m_rr + i) % N_REQ;
        if (tb_valid[k] && !is_waiting(k)) elig.push_back(k);
      end
    end
    if (elig.size() > 0) begin
      m_a = elig[0];
      if (owner[id_of(m_a)] < 0)
        for (int j = 1; j < elig.size(); j++)
          if (m_b < 0 && id_of(elig[j]) == id_of(m_a)) m_b = elig[j];
      if (m_b < 0)
        for (int j = 1; j < elig.size(); j++)
          if (m_b < 0 && id_of(elig[j]) != id_of(m_a)) m_b = elig[j];
      exp_ready[m_a]          = 1'b1;
      exp_rf_check[0]         = 1'b1;
      exp_rf_id[IDW-1:0]      = IDW'(id_of(m_a));
      exp_rf_id[2*IDW-1:IDW]  = IDW'(id_of(m_a) ^ 1);
      if (m_b >= 0) begin
        exp_ready[m_b]          = 1'b1;
        exp_rf_check[1]         = 1'b1;
        exp_rf_id[2*IDW-1:IDW]  = IDW'(id_of(m_b));
      end
    end
  endtask

  task automatic model_commit();
    int preq[2];
    int k, id;
    bit pair;
    exp_rsp_valid = '0;
    exp_status    = '0;
    exp_wake      = '0;
    if (tb_rst) begin
      for (int i = 0; i < N_REGS; i++) owner[i] = -1;
      m_rr = 0;
      return;
    end
    preq[0] = m_a;
    preq[1] = m_b;
    pair = (m_b >= 0) && (id_of(m_a) == id_of(m_b));
    for (int p = 0; p < 2; p++) begin
      k = preq[p];
      if (k < 0) continue;
      id = id_of(k);
      exp_rsp_valid[k] = 1'b1;
      if (inj_err[p]) exp_status[2*k +: 2] = 2'b10;
      else if (pair) exp_status[2*k +: 2] = 2'b01;
      else if (owner[id] >= 0) begin
        exp_status[2*k +: 2] = 2'b01;
        exp_wake[owner[id]] = 1'b1;
        owner[id] = -1;
      end else begin
        exp_status[2*k +: 2] = 2'b00;
        owner[id] = k;
      end
    end
    if (m_a >= 0) m_rr = (m_a + 1) % N_REQ;
  endtask

  task automatic begin_cycle();
    @(negedge clk_i);
    rst_i       = tb_rst;
    req_valid_i = tb_valid;
    req_id_i    = tb_id;
    #1;
    model_grant();
  endtask

  task automatic end_cycle();
    @(posedge clk_i);
    model_commit();
    #1;
  endtask

  task automatic set_req(input int k, input int id);
    tb_valid[k] = 1'b1;
    tb_id[k*IDW +: IDW] = IDW'(id);
  endtask

  task automatic do_reset();
    tb_rst = 1'b1;
    tb_valid = '0;
    begin_cycle();
    end_cycle();
    tb_rst = 1'b0;
  endtask

  task automatic test_reset();
    tb_rst = 1'b1;
    tb_valid = '1;
    tb_id = $urandom;
    for (int c = 0; c < 2; c++) begin
      begin_cycle();
      checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0000", req_ready_o); end
      checks++; if (rf_check_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_check: got %b want 00", rf_check_o); end
      checks++; if (rf_id_o !== 4'b0100) begin errors++; $display("[TB] FAIL reset_rf_id: got %b want 0100", rf_id_o); end
      end_cycle();
    end
    tb_rst = 1'b0;
    tb_valid = '0;
    checks++; if (rsp_valid_o !== 4'b0000 || wake_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp: got valid %b wake %b want 0000", rsp_valid_o, wake_o); end
  endtask

  task automatic test_store_sync();
    tb_valid = '0;
    set_req(0, 2);
    begin_cycle();
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("[TB] FAIL store_ready: got %b want 0001", req_ready_o); end
    end_cycle();
    checks++; if (rsp_valid_o !== 4'b0001 || rsp_status_o[1:0] !== 2'b00) begin errors++; $display("[TB] FAIL store_rsp: got valid %b status %b want 0001/00", rsp_valid_o, rsp_status_o); end
    tb_valid = '0;
    begin_cycle();
    end_cycle();
    checks++; if (rsp_valid_o !== 4'b0000) begin errors++; $display("[TB] FAIL store_pulse: got %b want 0000", rsp_valid_o); end
    set_req(1, 2);
    begin_cycle();
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL sync_ready: got %b want 0010", req_ready_o); end
    end_cycle();
    tb_valid = '0;
    checks++; if (rsp_status_o[3:2] !== 2'b01 || rsp_valid_o !== 4'b0010) begin errors++; $display("[TB] FAIL sync_rsp: got valid %b status %b want 0010/01", rsp_valid_o, rsp_status_o); end
    checks++; if (wake_o !== 4'b0001) begin errors++; $display("[TB] FAIL sync_wake: got %b want 0001", wake_o); end
    checks++; if (rf_mem[2] !== 1'b0) begin errors++; $display("[TB] FAIL sync_rf_entry: got %b want 0", rf_mem[2]); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_req(0, 3);
    set_req(2, 3);
    begin_cycle();
    checks++; if (req_ready_o !== 4'b0101) begin errors++; $display("[TB] FAIL bypass_ready: got %b want 0101", req_ready_o); end
    checks++; if (rf_id_o !== 4'b1111 || rf_check_o !== 2'b11) begin errors++; $display("[TB] FAIL bypass_rf: got id %b check %b want 1111/11", rf_id_o, rf_check_o); end
    end_cycle();
    tb_valid = '0;
    checks++; if (rsp_valid_o !== 4'b0101 || rsp_status_o !== 8'b0001_0001) begin errors++; $display("[TB] FAIL bypass_rsp: got valid %b status %b want 0101/00010001", rsp_valid_o, rsp_status_o); end
    checks++; if (wake_o !== 4'b0000 || rf_mem[3] !== 1'b0) begin errors++; $display("[TB] FAIL bypass_side: got wake %b entry %b want 0000/0", wake_o, rf_mem[3]); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < N_REQ; k++) set_req(k, k);
    for (int c = 0; c < 4; c++) begin
      begin_cycle();
      checks++; if (req_ready_o !== exp_ready) begin errors++; $display("[TB] FAIL rr_ready c%0d: got %b want %b", c, req_ready_o, exp_ready); end
      if (c == 0) begin
        checks++; if (req_ready_o !== 4'b0011) begin errors++; $display("[TB] FAIL rr_first: got %b want 0011", req_ready_o); end
      end else if (c == 1) begin
        checks++; if (req_ready_o !== 4'b1100) begin errors++; $display("[TB] FAIL rr_second: got %b want 1100", req_ready_o); end
      end else begin
        checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL rr_blocked: got %b want 0000", req_ready_o); end
      end
      end_cycle();
      checks++; if (rsp_valid_o !== exp_rsp_valid || rsp_status_o !== 8'h00) begin errors++; $display("[TB] FAIL rr_rsp c%0d: got %b/%b want %b/00000000", c, rsp_valid_o, rsp_status_o, exp_rsp_valid); end
    end
    tb_valid = '0;
  endtask

  task automatic test_protected();
    do_reset();
    set_req(0, 1);
    begin_cycle();
    end_cycle();
    tb_valid = '0;
    checks++; if (rsp_status_o[1:0] !== 2'b00 || rsp_valid_o !== 4'b0001) begin errors++; $display("[TB] FAIL prot_store: got %b/%b want 0001/00", rsp_valid_o, rsp_status_o); end
    set_req(1, 1);
    set_req(2, 1);
    begin_cycle();
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL prot_ready: got %b want 0010", req_ready_o); end
    checks++; if (rf_check_o !== 2'b01 || rf_id_o !== 4'b0001) begin errors++; $display("[TB] FAIL prot_rf: got id %b check %b want 0001/01", rf_id_o, rf_check_o); end
    end_cycle();
    tb_valid[1] = 1'b0;
    checks++; if (rsp_status_o[3:2] !== 2'b01 || wake_o !== 4'b0001) begin errors++; $display("[TB] FAIL prot_sync: got status %b wake %b want 01/0001", rsp_status_o, wake_o); end
    begin_cycle();
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("[TB] FAIL prot_next: got %b want 0100", req_ready_o); end
    end_cycle();
    tb_valid = '0;
    checks++; if (rsp_valid_o !== 4'b0100 || rsp_status_o[5:4] !== 2'b00) begin errors++; $display("[TB] FAIL prot_store2: got %b/%b want 0100/00", rsp_valid_o, rsp_status_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_req(0, 1);
    begin_cycle();
    end_cycle();
    tb_valid = '0;
    tb_rst = 1'b1;
    begin_cycle();
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_ready: got %b want 0000", req_ready_o); end
    end_cycle();
    tb_rst = 1'b0;
    checks++; if (rsp_valid_o !== 4'b0000 || wake_o !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_drop: got valid %b wake %b want 0000", rsp_valid_o, wake_o); end
    set_req(0, 2);
    set_req(1, 1);
    begin_cycle();
    checks++; if (req_ready_o !== 4'b0011) begin errors++; $display("[TB] FAIL midrst_regrant: got %b want 0011", req_ready_o); end
    end_cycle();
    tb_valid = '0;
    checks++; if (rsp_valid_o !== 4'b0011 || rsp_status_o !== 8'h00 || wake_o !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_store: got %b/%b wake %b want 0011/00000000/0000", rsp_valid_o, rsp_status_o, wake_o); end
  endtask

  task automatic test_id_err();
    do_reset();
    set_req(0, 0);
    inj_err = 2'b01;
    begin_cycle();
    end_cycle();
    inj_err = 2'b00;
    tb_valid = '0;
    checks++; if (rsp_status_o[1:0] !== 2'b10 || rsp_valid_o !== 4'b0001) begin errors++; $display("[TB] FAIL err_status: got %b/%b want 0001/10", rsp_valid_o, rsp_status_o); end
    set_req(1, 0);
    begin_cycle();
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL err_noblock: got %b want 0010", req_ready_o); end
    end_cycle();
    tb_valid = '0;
    checks++; if (rsp_status_o[3:2] !== 2'b00 || wake_o !== 4'b0000 || rf_mem[0] !== 1'b1) begin errors++; $display("[TB] FAIL err_store: got status %b wake %b entry %b want 00/0000/1", rsp_status_o, wake_o, rf_mem[0]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tb_rst = ($urandom_range(0, 49) == 0);
      inj_err = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      for (int k = 0; k < N_REQ; k++)
        if (!tb_valid[k] && $urandom_range(0, 2) == 0) set_req(k, $urandom_range(0, N_REGS-1));
      begin_cycle();
      checks++; if (req_ready_o !== exp_ready) begin errors++; $display("[TB] FAIL rand_ready c%0d: got %b want %b", c, req_ready_o, exp_ready); end
      checks++; if (rf_id_o !== exp_rf_id || rf_check_o !== exp_rf_check) begin errors++; $display("[TB] FAIL rand_rf c%0d: got %b/%b want %b/%b", c, rf_id_o, rf_check_o, exp_rf_id, exp_rf_check); end
      end_cycle();
      checks++; if (rsp_valid_o !== exp_rsp_valid || rsp_status_o !== exp_status) begin errors++; $display("[TB] FAIL rand_rsp c%0d: got %b/%b want %b/%b", c, rsp_valid_o, rsp_status_o, exp_rsp_valid, exp_status); end
      checks++; if (wake_o !== exp_wake) begin errors++; $display("[TB] FAIL rand_wake c%0d: got %b want %b", c, wake_o, exp_wake); end
      if (m_a >= 0) tb_valid[m_a] = 1'b0;
      if (m_b >= 0) tb_valid[m_b] = 1'b0;
    end
    tb_rst = 1'b0;
    inj_err = 2'b00;
    tb_valid = '0;
  endtask

  initial begin
    test_reset();
    test_store_sync();
    test_bypass();
    test_round_robin();
    test_protected();
    test_mid_reset();
    test_id_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
